alu_share_arbiter: RTL
======================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; all data ports are WIDTH bits.
REQ-002 Parameter OPW, default 3, ALU opcode width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_op  input  OPW  requester 0 opcode.
REQ-007 req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-008 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-009 req1_valid, req1_op, req1_a, req1_b, req1_ready SHALL mirror REQ-005..008 for requester 1.
REQ-010 alu_op  output  OPW  opcode driven to the shared combinational ALU.
REQ-011 alu_a, alu_b  output  WIDTH  operands driven to the shared ALU.
REQ-012 alu_result  input  WIDTH  shared ALU result, combinational from alu_op/alu_a/alu_b.
REQ-013 resp_valid  output  1  response held in resp_data.
REQ-014 resp_id  output  1  requester owning the response (0 or 1).
REQ-015 resp_data  output  WIDTH  registered ALU result.
REQ-016 resp_ready  input  1  consumer takes response this cycle.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, RESP; only one operation is in flight at a time.
REQ-018 In IDLE, a request is accepted when its valid is high and it wins arbitration; reqN_ready is combinational, high only in IDLE for the winner.
REQ-019 Arbitration SHALL be round-robin: with both valid, grant goes to the requester not granted last; with one valid, it wins regardless.
REQ-020 Last-grant pointer SHALL update only on acceptance, to the accepted id.
REQ-021 On acceptance: op, a, b and id are registered; IDLE -> EXEC.
REQ-022 alu_op/alu_a/alu_b SHALL always drive the registered op/operands (no combinational path from req ports to ALU).
REQ-023 In EXEC (exactly one cycle): alu_result captured into resp_data, id into resp_id; EXEC -> RESP.
REQ-024 In RESP: resp_valid high; resp_data/resp_id stable until resp_ready high, then RESP -> IDLE.
REQ-025 resp_valid SHALL be low in IDLE and EXEC; no request accepted in EXEC or RESP (both ready low).
REQ-026 Accept-to-resp_valid latency: 2 cycles; back-to-back throughput: one operation per 3 cycles with resp_ready held high.
REQ-027 A requester deasserting valid before acceptance SHALL have no effect on state.
REQ-028 resp_ready while not in RESP SHALL be ignored.
REQ-029 No operand/opcode interpretation; results are whatever alu_result returns, WIDTH bits, no truncation or extension.

Reset
REQ-030 Reset asserted at any time, including mid-EXEC or mid-RESP, SHALL immediately force IDLE, discarding the in-flight operation.
REQ-031 Reset values: resp_valid 0, resp_id 0, resp_data 0, registered op/a/b 0 (hence alu_op/alu_a/alu_b 0), last-grant pointer 1 (requester 0 wins first tie).
REQ-032 reqN_ready SHALL be low while reset is high.

Verification
REQ-033 Single request: req0 OR op, a=0xF0F0_0000, b=0x0000_0F0F -> req0_ready cycle T; resp_valid T+2 with resp_id 0, resp_data 0xF0F0_0F0F.
REQ-034 Tie after reset: both valid -> req0 granted first; both still valid after its response -> req1 granted; then req0 again (alternation).
REQ-035 Backpressure: resp_ready low 5 cycles in RESP -> resp_valid/resp_data/resp_id stable, both ready low throughout; resp_ready high -> IDLE next cycle.
REQ-036 Single-requester streaming: only req1 valid continuously with resp_ready high -> req1 granted every 3 cycles despite last grant being 1.
REQ-037 Reset mid-EXEC: assert reset during EXEC -> resp_valid never asserts for that operation; all outputs at REQ-031 values; next tie granted to req0.
REQ-038 Withdrawn request: req1_valid pulses high one cycle while in RESP -> never accepted, pointer unchanged.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// One operation in flight: IDLE accepts, EXEC captures, RESP holds the result.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    input  logic             resp_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_last;
    logic             r_id;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_resp_valid;
    logic             r_resp_id;
    logic [WIDTH-1:0] r_resp_data;

    logic             w_idle;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic [OPW-1:0]   w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;

    // Round-robin grant: a lone requester always wins, a tie goes to the one not granted last
    always_comb begin
        w_idle   = (r_state == IDLE) && !reset;
        w_grant0 = w_idle && req0_valid && (!req1_valid || r_last);
        w_grant1 = w_idle && req1_valid && (!req0_valid || !r_last);
        w_accept = w_grant0 || w_grant1;
    end

    // Operand mux selecting the winning requester's payload for capture
    always_comb begin
        w_sel_op = req0_op;
        w_sel_a  = req0_a;
        w_sel_b  = req0_b;
        if (w_grant1) begin
            w_sel_op = req1_op;
            w_sel_a  = req1_a;
            w_sel_b  = req1_b;
        end
    end

    // Control FSM with registered operands, pointer and response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last       <= 1'b1;
            r_id         <= 1'b0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_sel_op;
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_id    <= w_grant1;
                        r_last  <= w_grant1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_resp_data  <= alu_result;
                    r_resp_id    <= r_id;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    // The ALU only ever sees registered values
    always_comb begin
        req0_ready = w_grant0;
        req1_ready = w_grant1;
        alu_op     = r_op;
        alu_a      = r_a;
        alu_b      = r_b;
        resp_valid = r_resp_valid;
        resp_id    = r_resp_id;
        resp_data  = r_resp_data;
    end

endmodule
